// File: rtl/vip_frame_ctrl.sv
// Frame tracker for a vsync/href/clken video stream: detects frame boundaries, counts lines and
// frames, and applies host mode changes only at frame start. Optional geometry check: VIP_FRAME_SIZE_CHECK_EN.
module vip_frame_ctrl #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int CNT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic             cfg_req,
  input  logic [3:0]       cfg_mode,
  output logic             cfg_ack,
  output logic [3:0]       active_mode,
  output logic             frame_start,
  output logic             frame_done,
  output logic             busy,
  output logic [15:0]      frame_cnt,
  output logic [CNT_W-1:0] line_cnt,
  output logic             size_err
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FRAME = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LP_CNT_ONE = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_vs_d;
  logic             r_hs_d;
  logic             w_vs_rise;
  logic             w_vs_fall;
  logic             w_hs_fall;
  logic             w_start;
  logic             w_end;
  logic             w_pix_hit;
  logic             w_line_end;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [CNT_W-1:0] r_line_cnt;
  logic [CNT_W-1:0] w_pix_inc;
  logic [CNT_W-1:0] w_line_inc;
  logic [CNT_W-1:0] w_line_final;
  logic             r_cfg_ack;
  logic [3:0]       r_active_mode;
  logic             r_frame_start;
  logic [15:0]      r_frame_cnt;
  logic [CNT_W-1:0] r_line_total;

  // vs_d resets high so a frame already running at reset release never produces a rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs_d <= 1'b1;
      r_hs_d <= 1'b0;
    end else begin
      r_vs_d <= per_frame_vsync;
      r_hs_d <= per_frame_href;
    end
  end

  assign w_vs_rise = per_frame_vsync & ~r_vs_d;
  assign w_vs_fall = ~per_frame_vsync & r_vs_d;
  assign w_hs_fall = ~per_frame_href & r_hs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_vs_rise) w_state_nxt = ST_FRAME;
      ST_FRAME: if (w_vs_fall) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_start = (r_state == ST_IDLE) & w_vs_rise;
  assign w_end   = (r_state == ST_FRAME) & w_vs_fall;

  // A line still open when vsync drops is closed in that same cycle.
  assign w_pix_hit    = per_frame_href & per_frame_clken;
  assign w_line_end   = w_hs_fall | (w_vs_fall & per_frame_href);
  assign w_pix_inc    = (r_pix_cnt == LP_CNT_MAX) ? r_pix_cnt : r_pix_cnt + LP_CNT_ONE;
  assign w_line_inc   = (r_line_cnt == LP_CNT_MAX) ? r_line_cnt : r_line_cnt + LP_CNT_ONE;
  assign w_line_final = w_line_end ? w_line_inc : r_line_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (w_start) begin
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
    end else if (r_state == ST_FRAME) begin
      if (w_line_end) begin
        r_pix_cnt  <= '0;
        r_line_cnt <= w_line_inc;
      end else if (w_pix_hit) begin
        r_pix_cnt  <= w_pix_inc;
      end
    end
  end

  // The mode is only ever sampled at frame start, so a frame never sees two modes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cfg_ack     <= 1'b0;
      r_active_mode <= 4'd0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= 16'd0;
      r_line_total  <= '0;
    end else begin
      r_frame_start <= w_start;
      r_cfg_ack     <= w_start & cfg_req;
      if (w_start && cfg_req) begin
        r_active_mode <= cfg_mode;
      end
      if (w_end) begin
        r_frame_cnt  <= r_frame_cnt + 16'd1;
        r_line_total <= w_line_final;
      end
    end
  end

`ifdef VIP_FRAME_SIZE_CHECK_EN
  localparam logic [CNT_W-1:0] LP_H_ACT = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] LP_V_ACT = CNT_W'(V_ACT);

  logic [CNT_W-1:0] w_pix_len;
  logic             w_len_bad;
  logic             r_len_flag;
  logic             r_size_err;

  assign w_pix_len = w_pix_hit ? w_pix_inc : r_pix_cnt;
  assign w_len_bad = w_line_end & (w_pix_len != LP_H_ACT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_flag <= 1'b0;
      r_size_err <= 1'b0;
    end else begin
      if (w_start) begin
        r_len_flag <= 1'b0;
      end else if ((r_state == ST_FRAME) && w_len_bad) begin
        r_len_flag <= 1'b1;
      end
      if (w_end) begin
        r_size_err <= r_len_flag | w_len_bad | (w_line_final != LP_V_ACT);
      end
    end
  end

  assign size_err = r_size_err;
`else
  assign size_err = 1'b0;
`endif

  assign cfg_ack     = r_cfg_ack;
  assign active_mode = r_active_mode;
  assign frame_start = r_frame_start;
  assign frame_done  = (r_state == ST_DONE);
  assign busy        = (r_state == ST_FRAME);
  assign frame_cnt   = r_frame_cnt;
  assign line_cnt    = r_line_total;

endmodule

// File: doc/vip_frame_ctrl.md
VIP_FRAME_CTRL -- requirements
Module: vip_frame_ctrl

Interface
REQ-001 The block SHALL have parameter H_ACT, default 640: expected active pixels per line.
REQ-002 The block SHALL have parameter V_ACT, default 480: expected active lines per frame.
REQ-003 The block SHALL have parameter CNT_W, default 12: width of the pixel and line counters.
REQ-004 The block SHALL have port clk, input, 1 bit: single pixel clock for all logic.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port per_frame_vsync, input, 1 bit: frame valid, high for the whole frame.
REQ-007 The block SHALL have port per_frame_href, input, 1 bit: line valid, high for the whole line.
REQ-008 The block SHALL have port per_frame_clken, input, 1 bit: pixel qualifier.
REQ-009 The block SHALL have port cfg_req, input, 1 bit: host mode-change request, held until cfg_ack.
REQ-010 The block SHALL have port cfg_mode, input, 4 bits: requested processing mode, stable while cfg_req is high.
REQ-011 The block SHALL have port cfg_ack, output, 1 bit: one-cycle pulse when the request is applied.
REQ-012 The block SHALL have port active_mode, output, 4 bits: mode driven to the processing pipeline (post_img_mode source).
REQ-013 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at accepted frame start.
REQ-014 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 The block SHALL have port busy, output, 1 bit: high while a frame is being tracked.
REQ-016 The block SHALL have port frame_cnt, output, 16 bits: completed-frame counter.
REQ-017 The block SHALL have port line_cnt, output, CNT_W bits: line count of the last completed frame.
REQ-018 The block SHALL have port size_err, output, 1 bit: geometry mismatch flag for the last completed frame.

Function
REQ-019 vsync and href SHALL be registered once (vs_d, hs_d); vs_rise = vsync & ~vs_d, vs_fall = ~vsync & vs_d, hs_fall = ~href & hs_d.
REQ-020 The FSM SHALL have states IDLE, FRAME and DONE: IDLE->FRAME on vs_rise; FRAME->DONE on vs_fall; DONE->IDLE unconditionally after 1 cycle.
REQ-021 A vs_rise in DONE SHALL be ignored; busy SHALL be 1 exactly in FRAME.
REQ-022 frame_start SHALL be registered and high the cycle after the IDLE->FRAME edge.
REQ-023 frame_done SHALL be high while in DONE, i.e. 1 cycle after the vs_fall edge.
REQ-024 On the IDLE->FRAME edge with cfg_req=1, active_mode SHALL load cfg_mode and cfg_ack SHALL pulse the next cycle; otherwise active_mode SHALL hold.
REQ-025 A request SHALL never change active_mode mid-frame: cfg_req rising in FRAME waits for the next frame start, and one whole frame always uses one mode.
REQ-026 If cfg_req is still high after cfg_ack, it SHALL be re-applied at the following frame start (idempotent).
REQ-027 In FRAME, a pixel counter SHALL increment on href&clken and clear on hs_fall; a line counter SHALL increment on hs_fall.
REQ-028 Both counters SHALL saturate at 2^CNT_W-1 with no wrap; both SHALL clear on entry to FRAME.
REQ-029 If href is still high at vs_fall, the open line SHALL count as a line (treated as hs_fall in the same cycle).
REQ-030 On entry to DONE, line_cnt SHALL take the line counter value and frame_cnt SHALL increment, wrapping 0xFFFF->0.

Reset
REQ-031 While rst_n=0: state=IDLE; active_mode=0; cfg_ack, frame_start, frame_done, busy, size_err=0; frame_cnt and line_cnt=0; internal counters=0.
REQ-032 vs_d SHALL reset to 1 so that a frame already in progress at reset release is skipped; hs_d SHALL reset to 0.
REQ-033 Reset asserted mid-frame SHALL drop any pending request without cfg_ack; tracking resumes at the next complete frame.

Configuration
REQ-034 With macro VIP_FRAME_SIZE_CHECK_EN defined, a mismatch flag SHALL be set in FRAME whenever a completed line length != H_ACT.
REQ-035 With VIP_FRAME_SIZE_CHECK_EN defined, on entry to DONE size_err SHALL be loaded with (flag | line count != V_ACT) and hold until the next DONE.
REQ-036 Without VIP_FRAME_SIZE_CHECK_EN, the check logic SHALL be absent and size_err SHALL be tied to 0.

Verification
REQ-037 H_ACT=4, V_ACT=3; 3 lines of 4 clken pixels -> frame_start 1 cycle after vsync rise; frame_done 1 cycle after vsync fall; line_cnt=3; frame_cnt=1; size_err=0.
REQ-038 cfg_req=1, cfg_mode=5 raised mid-frame -> active_mode stays 0 until the next vsync rise, becomes 5 on it, cfg_ack pulses once.
REQ-039 With the macro defined, a frame whose 2nd line has 3 pixels -> size_err=1 at frame_done; the next correct frame clears it to 0.
REQ-040 vsync high at reset release, then falls -> no frame_done; the next full frame gives frame_cnt=1.
REQ-041 frame_cnt preset by 65535 frames -> the next frame_done gives frame_cnt=0.
REQ-042 rst_n pulled low mid-frame with cfg_req pending -> all outputs 0, no cfg_ack; the request applies at the first frame after reset.
